fifo_wptr_full: RTL and testbench

Write-domain pointer and full-flag generator for the asynchronous FIFO. Keeps the binary write pointer, drives the memory write address and enable, and publishes the Gray-coded write pointer for the read-domain synchronizer. Consumes the read pointer after it has been synchronized into the write domain, and derives full, fill level, almost-full and overflow status from it. Runs entirely on the write clock.

---
 rtl/fifo_wptr_full.sv | 95 +++++++++
 tb/tb_fifo_wptr_full.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full flag and fill-level generator for the asynchronous FIFO.
// Optional registered almost_full output is enabled by defining ALMOST_FULL_EN.
module fifo_wptr_full #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned AF_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic                  clr_ovf,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic [ADDR_WIDTH:0]   wcount,
  output logic                  almost_full,
  output logic                  overflow
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  // The full comparison inverts the top two Gray bits, so at least two are needed.
  if (ADDR_WIDTH < 2 || AF_MARGIN < 1 || AF_MARGIN > DEPTH - 1) begin : g_bad_params
    $error("fifo_wptr_full: ADDR_WIDTH must be >= 2 and AF_MARGIN in 1..DEPTH-1");
  end

  logic [PTR_W-1:0] wbin_q,  wbin_d;
  logic [PTR_W-1:0] wptr_q,  wptr_d;
  logic [PTR_W-1:0] wcount_q, wcount_d;
  logic             wfull_q, wfull_d;
  logic             almost_full_q, almost_full_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] rbin_s;

  assign wen = winc & ~wfull_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rbin_s   = '0;
    wbin_d   = wbin_q;
    wptr_d   = wptr_q;
    wfull_d  = wfull_q;
    wcount_d = wcount_q;

    rbin_s[PTR_W-1] = wq2_rptr[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
    end

    wbin_d   = wbin_q + {{ADDR_WIDTH{1'b0}}, wen};
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    // Full when the next write pointer is one lap ahead of the synchronized read pointer.
    wfull_d  = (wptr_d == {~wq2_rptr[PTR_W-1:PTR_W-2], wq2_rptr[PTR_W-3:0]});
    wcount_d = wbin_d - rbin_s;
  end

  always_comb begin
    almost_full_d = 1'b0;
`ifdef ALMOST_FULL_EN
    almost_full_d = (wcount_d >= PTR_W'(DEPTH - AF_MARGIN));
`endif
  end

  // A rejected write sets the sticky bit even when clr_ovf is pulsed in the same cycle.
  assign overflow_d = (winc & wfull_q) | (overflow_q & ~clr_ovf);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q        <= '0;
      wptr_q        <= '0;
      wfull_q       <= 1'b0;
      wcount_q      <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wptr_q        <= wptr_d;
      wfull_q       <= wfull_d;
      wcount_q      <= wcount_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign wptr        = wptr_q;
  assign wfull       = wfull_q;
  assign wcount      = wcount_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full with ADDR_WIDTH=3, AF_MARGIN=2.
module tb_fifo_wptr_full;

  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          winc;
  logic [AW:0]   wq2_rptr;
  logic          clr_ovf;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic [AW:0]   wcount;
  logic          almost_full;
  logic          overflow;

  int n_vec = 0;
  int n_bad = 0;

  fifo_wptr_full #(.ADDR_WIDTH(AW), .AF_MARGIN(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .winc        (winc),
    .wq2_rptr    (wq2_rptr),
    .clr_ovf     (clr_ovf),
    .wen         (wen),
    .waddr       (waddr),
    .wptr        (wptr),
    .wfull       (wfull),
    .wcount      (wcount),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          winc;
    logic [AW:0]   rptr;
    logic          clr;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          full;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          af;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic af_exp(input logic v);
`ifdef ALMOST_FULL_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  initial begin
    //              winc  rptr   clr   wen   waddr wptr    full  cnt   ovf   af
    vecs[0]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd1, 4'b0001, 1'b0, 4'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd2, 4'b0011, 1'b0, 4'd2, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd3, 4'b0010, 1'b0, 4'd3, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd4, 4'b0110, 1'b0, 4'd4, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd5, 4'b0111, 1'b0, 4'd5, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd6, 4'b0101, 1'b0, 4'd6, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd7, 4'b0100, 1'b0, 4'd7, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 4'h0, 1'b0, 1'b1, 3'd0, 4'b1100, 1'b1, 4'd8, 1'b0, 1'b1};
    // Writes while full are rejected and set the sticky overflow.
    vecs[8]  = '{1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 4'b1100, 1'b1, 4'd8, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 4'b1100, 1'b1, 4'd8, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 4'b1100, 1'b1, 4'd8, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 4'b1100, 1'b1, 4'd8, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 4'h0, 1'b1, 1'b0, 3'd0, 4'b1100, 1'b1, 4'd8, 1'b1, 1'b1};
    // Reader frees one slot, then a single write refills it.
    vecs[13] = '{1'b0, 4'h1, 1'b0, 1'b0, 3'd0, 4'b1100, 1'b0, 4'd7, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 4'h1, 1'b0, 1'b1, 3'd1, 4'b1101, 1'b1, 4'd8, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 4'h1, 1'b1, 1'b0, 3'd1, 4'b1101, 1'b1, 4'd8, 1'b0, 1'b1};

    rst_n    = 1'b0;
    winc     = 1'b0;
    wq2_rptr = '0;
    clr_ovf  = 1'b0;
    #12;
    check("rst_waddr",  32'(waddr), 0);
    check("rst_wptr",   32'(wptr), 0);
    check("rst_wfull",  32'(wfull), 0);
    check("rst_wcount", 32'(wcount), 0);
    check("rst_af",     32'(almost_full), 0);
    check("rst_ovf",    32'(overflow), 0);
    check("rst_wen",    32'(wen), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      winc     = vecs[i].winc;
      wq2_rptr = vecs[i].rptr;
      clr_ovf  = vecs[i].clr;
      #1;
      check($sformatf("v%0d_wen", i), 32'(wen), 32'(vecs[i].wen));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_waddr", i),  32'(waddr),       32'(vecs[i].waddr));
      check($sformatf("v%0d_wptr", i),   32'(wptr),        32'(vecs[i].wptr));
      check($sformatf("v%0d_wfull", i),  32'(wfull),       32'(vecs[i].full));
      check($sformatf("v%0d_wcount", i), 32'(wcount),      32'(vecs[i].cnt));
      check($sformatf("v%0d_ovf", i),    32'(overflow),    32'(vecs[i].ovf));
      check($sformatf("v%0d_af", i),     32'(almost_full), 32'(af_exp(vecs[i].af)));
    end

    // Asynchronous reset between clock edges, while full with overflow pending.
    winc    = 1'b1;
    clr_ovf = 1'b0;
    @(posedge clk);
    #2;
    winc  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_waddr",  32'(waddr), 0);
    check("arst_wptr",   32'(wptr), 0);
    check("arst_wfull",  32'(wfull), 0);
    check("arst_wcount", 32'(wcount), 0);
    check("arst_af",     32'(almost_full), 0);
    check("arst_ovf",    32'(overflow), 0);
    wq2_rptr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    winc  = 1'b1;
    #1;
    check("post_rst_waddr", 32'(waddr), 0);
    check("post_rst_wen",   32'(wen), 1);
    @(posedge clk);
    #1;
    check("post_rst_wptr", 32'(wptr), 1);

    // Wrap: reader trails the writer, so the pointer laps without ever going full.
    rst_n = 1'b0;
    winc  = 1'b0;
    #1;
    rst_n = 1'b1;
    begin
      logic [AW:0] b;
      logic [AW:0] rb;
      logic [AW:0] prev;
      b    = '0;
      prev = '0;
      for (int i = 0; i < 20; i++) begin
        rb       = (i >= 1) ? b - 4'd1 : 4'd0;
        wq2_rptr = gray(rb);
        winc     = 1'b1;
        @(posedge clk);
        #1;
        b = b + 4'd1;
        check($sformatf("wrap%0d_wptr", i),  32'(wptr), 32'(gray(b)));
        check($sformatf("wrap%0d_hd1", i),   32'($countones(wptr ^ prev)), 1);
        check($sformatf("wrap%0d_wfull", i), 32'(wfull), 0);
        prev = wptr;
      end
      check("wrap_wcount", 32'(wcount), 2);
      check("wrap_waddr",  32'(waddr), 4);
    end
    winc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
